// File: rtl/rv32_pkg.sv
// rv32_pkg: shared FSM encoding and constants for the rv32 memory arbiter
package rv32_pkg;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_IF_ACC  = 2'd1;
  localparam logic [1:0] S_D_ACC   = 2'd2;
  localparam logic [1:0] S_RD_WAIT = 2'd3;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam int TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/rv32_arb_select.sv
// rv32_arb_select: picks fetch or data port; round-robin with RV32_ARB_ROUND_ROBIN_EN, else fixed priority
module rv32_arb_select import rv32_pkg::*; #(
  parameter int DATA_FIRST = 1
) (
  input  logic i_if_req,
  input  logic i_d_req,
  input  logic i_last_d,
  output logic o_sel_d
);
`ifdef RV32_ARB_ROUND_ROBIN_EN
  logic w_unused_df;
  assign w_unused_df = DATA_FIRST[0];
  assign o_sel_d = i_d_req & (~i_if_req | ~i_last_d);
`else
  logic w_unused_last;
  assign w_unused_last = i_last_d;
  assign o_sel_d = i_d_req & (~i_if_req | (DATA_FIRST != 0));
`endif
endmodule

// File: rtl/rv32_mem_arbiter.sv
// rv32_mem_arbiter: single-outstanding arbiter of fetch and data ports onto one memory bus
// Define RV32_ARB_ROUND_ROBIN_EN to replace fixed DATA_FIRST priority with round-robin.
module rv32_mem_arbiter import rv32_pkg::*; #(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
  parameter int DATA_FIRST     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic [31:0] if_rdata,
  output logic        if_rvalid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic [31:0] d_rdata,
  output logic        d_rvalid,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_waitreq,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        stall
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0]    r_state;
  logic          r_own_d, r_last_d, r_we;
  logic [3:0]    r_be;
  logic [31:0]   r_addr, r_wdata, r_if_rdata, r_d_rdata;
  logic [CW-1:0] r_cnt;
  logic          w_sel_d, w_idle, w_acc, w_accept, w_rv, w_to;
  rv32_arb_select #(.DATA_FIRST(DATA_FIRST)) u_sel (
    .i_if_req(if_req),
    .i_d_req (d_req),
    .i_last_d(r_last_d),
    .o_sel_d (w_sel_d)
  );
  assign w_idle   = r_state == S_IDLE;
  assign w_acc    = (r_state == S_IF_ACC) | (r_state == S_D_ACC);
  assign w_accept = w_acc & ~mem_waitreq;
  assign w_rv     = (r_state == S_RD_WAIT) & mem_rvalid;
  assign w_to     = (r_state == S_RD_WAIT) & ~mem_rvalid & (r_cnt == CW'(TIMEOUT_CYCLES));
  assign d_gnt    = w_idle & w_sel_d;
  assign if_gnt   = w_idle & if_req & ~w_sel_d;
  assign mem_req   = w_acc;
  assign mem_we    = r_we;
  assign mem_be    = r_be;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  // Responses are combinational so they land in the same cycle as mem_rvalid or the timeout.
  assign if_rvalid = ~r_own_d & (w_rv | w_to);
  assign if_rdata  = if_rvalid ? (w_rv ? mem_rdata : NOP) : r_if_rdata;
  assign d_rvalid  = r_own_d & w_rv;
  assign d_err     = r_own_d & w_to;
  assign d_rdata   = d_rvalid ? mem_rdata : r_d_rdata;
  assign stall     = d_gnt | (r_own_d & ~w_idle);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_own_d    <= 1'b0;
      r_last_d   <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      if (w_idle & (if_req | d_req)) begin
        r_state  <= w_sel_d ? S_D_ACC : S_IF_ACC;
        r_own_d  <= w_sel_d;
        r_last_d <= w_sel_d;
        r_we     <= w_sel_d & d_we;
        r_be     <= w_sel_d ? d_be : 4'hF;
        r_addr   <= w_sel_d ? d_addr : if_addr;
        r_wdata  <= w_sel_d ? d_wdata : '0;
      end
      if (w_accept) begin
        r_state <= r_we ? S_IDLE : S_RD_WAIT;
        r_cnt   <= CW'(1);
      end
      if (r_state == S_RD_WAIT) r_cnt <= r_cnt + CW'(1);
      if (w_rv | w_to) r_state <= S_IDLE;
      if (if_rvalid) r_if_rdata <= if_rdata;
      if (d_rvalid) r_d_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_rv32_mem_arbiter.sv
// tb_rv32_mem_arbiter: table, hand-written and random transactions checked against a transaction-level model
module tb_rv32_mem_arbiter;
  localparam int TO = 16;
  localparam logic [31:0] NOPV = 32'h00000013;
  logic clk = 1'b0, reset;
  logic if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid, d_err;
  logic mem_req, mem_we, mem_waitreq, mem_rvalid, stall;
  logic [3:0] d_be, mem_be;
  logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  int total = 0, bad = 0;
  bit m_last;
  logic [31:0] m_if, m_d;
  always #5 clk = ~clk;
  rv32_mem_arbiter #(.TIMEOUT_CYCLES(TO), .DATA_FIRST(1)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_err(d_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_waitreq(mem_waitreq), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .stall(stall)
  );
  typedef struct {
    bit wi, wd;
    logic [31:0] ia;
    int il;
    logic [31:0] da;
    bit dwe;
    logic [3:0] dbe;
    logic [31:0] dwd;
    int wn, dl;
    logic [31:0] rd;
    bit first_fp, first_rr;
  } vec_t;
  vec_t tv[7];
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask
  task automatic nextc;
    @(posedge clk);
    #1;
  endtask
  function automatic bit pick_d(bit wi, bit wd, bit last_d);
    if (!wi) return wd;
    if (!wd) return 1'b0;
`ifdef RV32_ARB_ROUND_ROBIN_EN
    return !last_d;
`else
    return 1'b1;
`endif
  endfunction
  task automatic chk_zero(string nm);
    chk({nm, "_ctl"}, 32'({mem_req, mem_we, mem_be, if_gnt, d_gnt, if_rvalid, d_rvalid, d_err, stall}), 32'd0);
    chk({nm, "_addr"}, mem_addr, 32'd0);
    chk({nm, "_wdata"}, mem_wdata, 32'd0);
    chk({nm, "_if_rdata"}, if_rdata, 32'd0);
    chk({nm, "_d_rdata"}, d_rdata, 32'd0);
  endtask
  // Entry: grant cycle with inputs settled. Exit: first IDLE cycle after the access, settled.
  task automatic serve(bit pd, bit we, logic [31:0] addr, logic [3:0] be, logic [31:0] wd,
                       int wn, int lat, logic [31:0] rd);
    logic [2:0] ev;
    logic [31:0] er_if, er_d;
    chk("gnt", 32'({if_gnt, d_gnt}), pd ? 32'd1 : 32'd2);
    chk("stall_gnt", 32'(stall), 32'(pd));
    chk("no_resp_idle", 32'({if_rvalid, d_rvalid, d_err}), 32'd0);
    chk("if_rdata_hold", if_rdata, m_if);
    chk("d_rdata_hold", d_rdata, m_d);
    nextc;
    if (pd) d_req = 1'b0; else if_req = 1'b0;
    mem_rvalid = 1'b0;
    mem_waitreq = wn > 0;
    #1;
    for (int i = 0; i <= wn; i++) begin
      if (i > 0) begin
        nextc;
        mem_waitreq = i < wn;
        #1;
      end
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_addr", mem_addr, addr);
      chk("mem_be", 32'(mem_be), 32'(be));
      chk("mem_we", 32'(mem_we), 32'(we));
      if (we) chk("mem_wdata", mem_wdata, wd);
      chk("stall_acc", 32'(stall), 32'(pd));
      chk("no_gnt_busy", 32'({if_gnt, d_gnt}), 32'd0);
    end
    if (!we) begin
      for (int k = 1; k <= TO; k++) begin
        nextc;
        mem_rvalid = k == lat;
        mem_rdata = rd;
        #1;
        ev = 3'b000; er_if = m_if; er_d = m_d;
        if (k == lat) begin
          if (pd) begin ev = 3'b010; er_d = rd; end
          else begin ev = 3'b100; er_if = rd; end
        end else if (k == TO) begin
          if (pd) ev = 3'b001;
          else begin ev = 3'b100; er_if = NOPV; end
        end
        chk("mem_req_wait", 32'(mem_req), 32'd0);
        chk("stall_wait", 32'(stall), 32'(pd));
        chk("resp", 32'({if_rvalid, d_rvalid, d_err}), 32'(ev));
        chk("if_rdata", if_rdata, er_if);
        chk("d_rdata", d_rdata, er_d);
        m_if = er_if; m_d = er_d;
        if (k == lat || k == TO) break;
      end
    end
    nextc;
    mem_waitreq = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hBAD0BAD0;
    #1;
  endtask
  task automatic run_round(bit wi, bit wd, logic [31:0] ia, int il, logic [31:0] da, bit dwe,
                           logic [3:0] dbe, logic [31:0] dwd, int wn, int dl, logic [31:0] rd, bit first);
    if_req = wi; if_addr = ia;
    d_req = wd; d_we = dwe; d_be = dbe; d_addr = da; d_wdata = dwd;
    #1;
    for (int n = 0; n < 2; n++) begin
      bit p;
      p = (n == 0) ? first : !first;
      if (n == 1 && !(wi && wd)) break;
      if (p) serve(1'b1, dwe, da, dbe, dwd, wn, dl, ~rd);
      else serve(1'b0, 1'b0, ia, 4'hF, 32'd0, wn, il, rd);
      m_last = p;
    end
    chk("idle_after", 32'({if_gnt, d_gnt, stall, mem_req, if_rvalid, d_rvalid, d_err}), 32'd0);
    nextc;
    mem_rvalid = 1'b0;
  endtask
  initial begin
    tv[0] = '{1, 0, 32'h100, 2, 32'h0, 0, 4'h0, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0};
    tv[1] = '{1, 1, 32'h104, 1, 32'h200, 1, 4'hF, 32'h55AA55AA, 0, 0, 32'h12345678, 1, 1};
    tv[2] = '{0, 1, 32'h0, 0, 32'h208, 0, 4'h3, 32'h0, 3, 2, 32'hCAFEF00D, 1, 1};
    tv[3] = '{0, 1, 32'h0, 0, 32'h20C, 0, 4'hF, 32'h0, 0, 20, 32'h11112222, 1, 1};
    tv[4] = '{1, 1, 32'h108, 4, 32'h210, 1, 4'h5, 32'hA5A5A5A5, 1, 0, 32'h0BADF00D, 1, 0};
    tv[5] = '{1, 0, 32'h10C, 20, 32'h0, 0, 4'h0, 32'h0, 0, 0, 32'h33334444, 0, 0};
    tv[6] = '{1, 1, 32'h110, 3, 32'h214, 0, 4'hC, 32'h0, 2, 1, 32'h600DCAFE, 1, 1};
    reset = 1'b1;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    mem_waitreq = 0; mem_rvalid = 0; mem_rdata = 0;
    m_last = 0; m_if = 0; m_d = 0;
    nextc; nextc;
    chk_zero("reset");
    reset = 1'b0;
    nextc;
    for (int i = 0; i < 7; i++) begin
`ifdef RV32_ARB_ROUND_ROBIN_EN
      run_round(tv[i].wi, tv[i].wd, tv[i].ia, tv[i].il, tv[i].da, tv[i].dwe, tv[i].dbe, tv[i].dwd,
                tv[i].wn, tv[i].dl, tv[i].rd, tv[i].first_rr);
`else
      run_round(tv[i].wi, tv[i].wd, tv[i].ia, tv[i].il, tv[i].da, tv[i].dwe, tv[i].dbe, tv[i].dwd,
                tv[i].wn, tv[i].dl, tv[i].rd, tv[i].first_fp);
`endif
    end
    // Both requesters keep asking: round-robin alternates, fixed priority starves fetch.
    if_req = 1; if_addr = 32'h300;
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h400; d_wdata = 32'h0F0F0F0F;
    #1;
    for (int g = 0; g < 4; g++) begin
      bit e;
      e = pick_d(1'b1, 1'b1, m_last);
      if (e) serve(1'b1, 1'b1, 32'h400, 4'hF, 32'h0F0F0F0F, 0, 1, 32'h0);
      else serve(1'b0, 1'b0, 32'h300, 4'hF, 32'h0, 0, 1, 32'h70000000 + 32'(g));
      m_last = e;
      if_req = 1; d_req = 1;
      #1;
    end
    if_req = 0; d_req = 0;
    #1;
    chk("idle_cont", 32'({if_gnt, d_gnt, stall, mem_req}), 32'd0);
    nextc;
    mem_rvalid = 0;
    // Reset while a data read sits in RD_WAIT.
    d_req = 1; d_we = 0; d_addr = 32'h500; d_be = 4'hF;
    #1;
    chk("rst_gnt", 32'(d_gnt), 32'd1);
    nextc;
    d_req = 0;
    #1;
    chk("rst_acc", 32'(mem_req), 32'd1);
    nextc;
    #1;
    chk("rst_rdwait_stall", 32'(stall), 32'd1);
    reset = 1;
    nextc;
    reset = 0;
    mem_rvalid = 1; mem_rdata = 32'h99998888;
    #1;
    chk_zero("rst_mid");
    nextc;
    chk_zero("rst_late_rv");
    mem_rvalid = 0;
    m_last = 0; m_if = 0; m_d = 0;
    nextc;
    for (int r = 0; r < 40; r++) begin
      bit wi, wd;
      wi = 1'($urandom);
      wd = wi ? 1'($urandom) : 1'b1;
      run_round(wi, wd, $urandom, $urandom_range(1, TO + 2), $urandom, 1'($urandom), 4'($urandom),
                $urandom, $urandom_range(0, 3), $urandom_range(1, TO + 2), $urandom, pick_d(wi, wd, m_last));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
